// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, parity modes and the
// clocks-per-bit divisors produced by the baud-rate decoder.
package uart_pkg;

    localparam int unsigned UART_CNT_W = 18;

    localparam logic PARITY_MODE_EVEN = 1'b0;
    localparam logic PARITY_MODE_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    typedef logic [UART_CNT_W-1:0] cpb_t;

    // Divisor for each of the eight baud selections, slowest first.
    function automatic cpb_t baud_div(input logic [2:0] sel);
        cpb_t div;
        case (sel)
            3'd0:    div = cpb_t'(166667);
            3'd1:    div = cpb_t'(41667);
            3'd2:    div = cpb_t'(20833);
            3'd3:    div = cpb_t'(10417);
            3'd4:    div = cpb_t'(5208);
            3'd5:    div = cpb_t'(2604);
            3'd6:    div = cpb_t'(1302);
            default: div = cpb_t'(434);
        endcase
        return div;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Host-side handshake and status bundle of the UART transmitter.
interface uart_tx_if
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned CNT_W     = UART_CNT_W
);

    logic [CNT_W-1:0]     clks_per_bit;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 tx;
    logic                 tx_busy;
    logic                 tx_done;

    modport master (
        output clks_per_bit, tx_data, tx_valid,
        input  tx_ready, tx, tx_busy, tx_done
    );

    modport slave (
        input  clks_per_bit, tx_data, tx_valid,
        output tx_ready, tx, tx_busy, tx_done
    );

endinterface

// File: rtl/uart_bit_timer.sv
// Bit-time counter: latches clocks-per-bit on load and flags the last cycle of
// every bit period. Shared by the transmitter and receiver.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int unsigned CNT_W = UART_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] cpb,
    output logic             bit_tick
);

    localparam logic [CNT_W-1:0] MIN_CPB = CNT_W'(2);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cpb_q;
    logic [CNT_W-1:0] cpb_nxt;

    // Count 0..cpb-1 and wrap; degenerate divisors are clamped so a bit lasts at least two cycles.
    always_comb begin
        cpb_nxt = cpb_q;
        cnt_nxt = cnt;
        if (load) begin
            cpb_nxt = (cpb < MIN_CPB) ? MIN_CPB : cpb;
            cnt_nxt = '0;
        end else if (cnt == cpb_q - CNT_W'(1)) begin
            cnt_nxt = '0;
        end else begin
            cnt_nxt = cnt + CNT_W'(1);
        end
    end

    // Tick is registered: it is high exactly while the counter sits at its last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            cpb_q    <= MIN_CPB;
            bit_tick <= 1'b0;
        end else begin
            cnt      <= cnt_nxt;
            cpb_q    <= cpb_nxt;
            bit_tick <= (cnt_nxt == cpb_nxt - CNT_W'(1));
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: takes one word over valid/ready and shifts out start, data
// (LSB first), optional parity and stop bits on an idle-high line.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned CNT_W      = UART_CNT_W
) (
    input  logic       clk,
    input  logic       rst,
    uart_tx_if.slave   bus
);

    localparam int unsigned      IDX_W     = $clog2(DATA_BITS);
    localparam logic             PAR_INV   = (PARITY_ODD != 0) ? PARITY_MODE_ODD : PARITY_MODE_EVEN;
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

    tx_state_t            state;
    tx_state_t            state_nxt;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] shreg_nxt;
    logic [IDX_W-1:0]     idx;
    logic [IDX_W-1:0]     idx_nxt;
    logic                 par_q;
    logic                 par_nxt;
    logic                 tx_q;
    logic                 tx_nxt;
    logic                 busy_q;
    logic                 done_q;
    logic                 done_nxt;
    logic                 accept_c;
    logic                 bit_tick;

    uart_bit_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (accept_c),
        .cpb      (bus.clks_per_bit),
        .bit_tick (bit_tick)
    );

    // Next-state and next-output logic; idx counts data bits, then stop bits.
    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        idx_nxt   = idx;
        par_nxt   = par_q;
        tx_nxt    = tx_q;
        done_nxt  = 1'b0;
        accept_c  = 1'b0;

        unique case (state)
            IDLE: begin
                tx_nxt = 1'b1;
                if (bus.tx_valid && !rst) begin
                    accept_c  = 1'b1;
                    state_nxt = START;
                    tx_nxt    = 1'b0;
                    shreg_nxt = bus.tx_data;
                    par_nxt   = (^bus.tx_data) ^ PAR_INV;
                    idx_nxt   = '0;
                end
            end
            START: begin
                if (bit_tick) begin
                    state_nxt = DATA;
                    tx_nxt    = shreg[0];
                    shreg_nxt = shreg >> 1;
                    idx_nxt   = '0;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    if (idx == LAST_DATA) begin
                        idx_nxt = '0;
                        if (PARITY_EN != 0) begin
                            state_nxt = PARITY;
                            tx_nxt    = par_q;
                        end else begin
                            state_nxt = STOP;
                            tx_nxt    = 1'b1;
                        end
                    end else begin
                        idx_nxt   = idx + IDX_W'(1);
                        tx_nxt    = shreg[0];
                        shreg_nxt = shreg >> 1;
                    end
                end
            end
            PARITY: begin
                if (bit_tick) begin
                    state_nxt = STOP;
                    tx_nxt    = 1'b1;
                    idx_nxt   = '0;
                end
            end
            STOP: begin
                tx_nxt = 1'b1;
                if (bit_tick) begin
                    if (idx == LAST_STOP) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                        idx_nxt   = '0;
                    end else begin
                        idx_nxt = idx + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                tx_nxt    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            shreg  <= '0;
            idx    <= '0;
            par_q  <= 1'b0;
            tx_q   <= 1'b1;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            shreg  <= shreg_nxt;
            idx    <= idx_nxt;
            par_q  <= par_nxt;
            tx_q   <= tx_nxt;
            busy_q <= (state_nxt != IDLE);
            done_q <= done_nxt;
        end
    end

    assign bus.tx       = tx_q;
    assign bus.tx_busy  = busy_q;
    assign bus.tx_done  = done_q;
    assign bus.tx_ready = (state == IDLE) && !rst;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: frame table plus hand-written corner sequences, checked by a
// line monitor against a queue of expected frames.
module tb_uart_tx;
    import uart_pkg::*;

    typedef struct {
        logic [7:0] data;
        int         cpb;
    } exp_t;

    typedef struct {
        logic [7:0]  data;
        logic [17:0] cpb_in;
        int          cpb_eff;
    } vec_t;

    logic clk;
    logic rst;
    int   checks     = 0;
    int   failures   = 0;
    int   mon_frames = 0;
    exp_t sb_q[$];

    uart_tx_if #(.DATA_BITS(8), .CNT_W(18)) b0 ();
    uart_tx_if #(.DATA_BITS(8), .CNT_W(18)) b1 ();
    uart_tx_if #(.DATA_BITS(8), .CNT_W(18)) b2 ();

    uart_tx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1), .CNT_W(18))
        dut0 (.clk(clk), .rst(rst), .bus(b0));
    uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1), .CNT_W(18))
        dut1 (.clk(clk), .rst(rst), .bus(b1));
    uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1), .CNT_W(18))
        dut2 (.clk(clk), .rst(rst), .bus(b2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge: waits for ready, queues the expected frame, pulses valid.
    task automatic send0(input logic [7:0] d, input logic [17:0] cpb, input int eff);
        int n = 0;
        while (b0.tx_ready !== 1'b1 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000) chk("send_ready_timeout", 32'd0, 32'd1);
        sb_q.push_back('{data: d, cpb: eff});
        b0.tx_data      = d;
        b0.clks_per_bit = cpb;
        b0.tx_valid     = 1'b1;
        @(negedge clk);
        b0.tx_valid = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n = 0;
        while (mon_frames < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (mon_frames < target) chk("frame_timeout", 32'(mon_frames), 32'(target));
    endtask

    // Line monitor for dut0: every cycle of every bit must match the expected frame.
    initial begin : mon
        exp_t       e;
        logic [9:0] bits;
        int         bad;
        bit         aborted;
        int         n;
        forever begin
            @(negedge clk);
            if (!rst && b0.tx === 1'b0) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_start", 32'd1, 32'd0);
                    n = 0;
                    while (b0.tx === 1'b0 && n < 100000) begin
                        @(negedge clk);
                        n++;
                    end
                end else begin
                    e       = sb_q.pop_front();
                    bits    = {1'b1, e.data, 1'b0};
                    aborted = 1'b0;
                    for (int b = 0; b < 10; b++) begin
                        bad = 0;
                        for (int c = 0; c < e.cpb; c++) begin
                            if (b != 0 || c != 0) @(negedge clk);
                            if (rst) begin
                                aborted = 1'b1;
                                break;
                            end
                            if (b0.tx !== bits[b] || b0.tx_done !== 1'b0 || b0.tx_busy !== 1'b1) bad++;
                        end
                        if (aborted) break;
                        chk($sformatf("frame%0d_data%0h_bit%0d_bad_cycles", mon_frames, e.data, b),
                            32'(bad), 32'd0);
                    end
                    if (!aborted) begin
                        @(negedge clk);
                        chk($sformatf("frame%0d_done_pulse", mon_frames), 32'(b0.tx_done), 32'd1);
                        chk($sformatf("frame%0d_done_ready", mon_frames), 32'(b0.tx_ready), 32'd1);
                        chk($sformatf("frame%0d_done_idle_busy", mon_frames), 32'(b0.tx_busy), 32'd0);
                        mon_frames++;
                    end
                end
            end
        end
    end

    initial begin : main
        vec_t vecs [5];
        int   base;
        int   n;

        vecs[0] = '{data: 8'hA5, cpb_in: baud_div(3'd7), cpb_eff: 434};
        vecs[1] = '{data: 8'h00, cpb_in: 18'd3,          cpb_eff: 3};
        vecs[2] = '{data: 8'hFF, cpb_in: 18'd2,          cpb_eff: 2};
        vecs[3] = '{data: 8'h3C, cpb_in: 18'd1,          cpb_eff: 2};
        vecs[4] = '{data: 8'h81, cpb_in: 18'd0,          cpb_eff: 2};

        // Reset with valid asserted: nothing accepted, line idle
        rst = 1'b1;
        b0.tx_valid = 1'b1; b0.tx_data = 8'hFF; b0.clks_per_bit = 18'd434;
        b1.tx_valid = 1'b1; b1.tx_data = 8'hFF; b1.clks_per_bit = 18'd16;
        b2.tx_valid = 1'b1; b2.tx_data = 8'hFF; b2.clks_per_bit = 18'd16;
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(b0.tx), 32'd1);
        chk("rst_busy", 32'(b0.tx_busy), 32'd0);
        chk("rst_done", 32'(b0.tx_done), 32'd0);
        chk("rst_ready", 32'(b0.tx_ready), 32'd0);
        chk("rst_ready_par", 32'(b1.tx_ready), 32'd0);
        b0.tx_valid = 1'b0;
        b1.tx_valid = 1'b0;
        b2.tx_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", 32'(b0.tx_ready), 32'd1);
        chk("idle_tx", 32'(b0.tx), 32'd1);

        // Frame table, including clamped divisors 1 and 0
        for (int i = 0; i < 5; i++) begin
            base = mon_frames;
            send0(vecs[i].data, vecs[i].cpb_in, vecs[i].cpb_eff);
            wait_frames(base + 1, 20000);
        end

        // Parity, 0x07 has three ones: even -> 1, odd -> 0; 11 bits of 16 cycles
        b1.tx_data = 8'h07; b1.clks_per_bit = 18'd16; b1.tx_valid = 1'b1;
        b2.tx_data = 8'h07; b2.clks_per_bit = 18'd16; b2.tx_valid = 1'b1;
        @(negedge clk);
        b1.tx_valid = 1'b0;
        b2.tx_valid = 1'b0;
        for (int c = 0; c <= 176; c++) begin
            if (c == 8)            chk("par_start_bit", 32'(b1.tx), 32'd0);
            if (c == 8 * 16 + 8)   chk("par_data_bit7", 32'(b1.tx), 32'd0);
            if (c == 9 * 16 + 8)   chk("par_even_bit", 32'(b1.tx), 32'd1);
            if (c == 9 * 16 + 8)   chk("par_odd_bit", 32'(b2.tx), 32'd0);
            if (c == 10 * 16 + 8)  chk("par_stop_bit", 32'(b2.tx), 32'd1);
            if (c == 175)          chk("par_done_early", 32'(b1.tx_done), 32'd0);
            if (c == 176)          chk("par_done_even_176", 32'(b1.tx_done), 32'd1);
            if (c == 176)          chk("par_done_odd_176", 32'(b2.tx_done), 32'd1);
            @(negedge clk);
        end

        // Back-to-back with valid held high: no extra frame, start right after done
        base = mon_frames;
        sb_q.push_back('{data: 8'h55, cpb: 16});
        sb_q.push_back('{data: 8'hAA, cpb: 16});
        b0.tx_data = 8'h55; b0.clks_per_bit = 18'd16; b0.tx_valid = 1'b1;
        @(negedge clk);
        b0.tx_data = 8'hAA;
        n = 0;
        while (b0.tx_done !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) chk("b2b_done_timeout", 32'd0, 32'd1);
        chk("b2b_done_tx_high", 32'(b0.tx), 32'd1);
        @(negedge clk);
        chk("b2b_next_start", 32'(b0.tx), 32'd0);
        chk("b2b_done_one_cycle", 32'(b0.tx_done), 32'd0);
        chk("b2b_busy", 32'(b0.tx_busy), 32'd1);
        b0.tx_valid = 1'b0;
        wait_frames(base + 2, 1000);

        // Asynchronous reset in the middle of data bit 3 of 0x96 (a zero)
        base = mon_frames;
        send0(8'h96, 18'd16, 16);
        repeat (64) @(negedge clk);
        @(posedge clk);
        #2;
        chk("pre_rst_tx_low", 32'(b0.tx), 32'd0);
        rst = 1'b1;
        #1;
        chk("async_rst_tx", 32'(b0.tx), 32'd1);
        chk("async_rst_busy", 32'(b0.tx_busy), 32'd0);
        chk("async_rst_ready", 32'(b0.tx_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send0(8'h3C, 18'd16, 16);
        wait_frames(base + 1, 1000);

        // Divisor change mid-frame only takes effect at the next accept
        base = mon_frames;
        send0(8'h5A, baud_div(3'd7), 434);
        repeat (2000) @(negedge clk);
        b0.clks_per_bit = baud_div(3'd4);
        wait_frames(base + 1, 6000);
        send0(8'hC3, baud_div(3'd4), 5208);
        wait_frames(base + 2, 60000);

        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        chk("total_frames", 32'(mon_frames), 32'd10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
